// File: rtl/cpu_defs.sv
// cpu_defs: shared definitions for the pipeline slice.
//   - inter-stage bus widths (fetch->decode, decode->execute, branch, dest tags)
//   - alu_op one-hot bit positions (bit 0 = add)
//   - instruction one-hot indices produced by inst_decode
//   - small decoder helpers used by the instruction decoder
package cpu_defs;

    localparam int FS_TO_DS_BUS_WD = 64;
    localparam int DS_TO_ES_BUS_WD = 136;
    localparam int BR_BUS_WD       = 33;
    localparam int DEST_BUS_WD     = 6;

    // alu_op one-hot positions
    localparam int ALU_OP_WD = 12;
    localparam int ALU_ADD   = 0;
    localparam int ALU_SUB   = 1;
    localparam int ALU_SLT   = 2;
    localparam int ALU_SLTU  = 3;
    localparam int ALU_AND   = 4;
    localparam int ALU_NOR   = 5;
    localparam int ALU_OR    = 6;
    localparam int ALU_XOR   = 7;
    localparam int ALU_SLL   = 8;
    localparam int ALU_SRL   = 9;
    localparam int ALU_SRA   = 10;
    localparam int ALU_LUI   = 11;

    // instruction one-hot positions
    localparam int INST_NUM = 19;
    localparam int I_ADDU   = 0;
    localparam int I_SUBU   = 1;
    localparam int I_SLT    = 2;
    localparam int I_SLTU   = 3;
    localparam int I_AND    = 4;
    localparam int I_OR     = 5;
    localparam int I_XOR    = 6;
    localparam int I_NOR    = 7;
    localparam int I_SLL    = 8;
    localparam int I_SRL    = 9;
    localparam int I_SRA    = 10;
    localparam int I_ADDIU  = 11;
    localparam int I_LUI    = 12;
    localparam int I_LW     = 13;
    localparam int I_SW     = 14;
    localparam int I_BEQ    = 15;
    localparam int I_BNE    = 16;
    localparam int I_JAL    = 17;
    localparam int I_JR     = 18;

    function automatic logic [63:0] decoder_6_64(input logic [5:0] in);
        return 64'd1 << in;
    endfunction

    function automatic logic [31:0] decoder_5_32(input logic [4:0] in);
        return 32'd1 << in;
    endfunction

endpackage

// File: rtl/inst_decode.sv
// inst_decode: purely combinational field split and instruction recognition.
// Ports:
//   inst      - 32-bit instruction word
//   rs/rt/rd  - register fields
//   imm       - raw 16-bit immediate
//   jidx      - 26-bit jump instr_index
//   inst_hit  - one-hot (at most one bit set) of recognised instructions;
//               all-zero for any encoding outside the supported set
module inst_decode
    import cpu_defs::*;
(
    input  logic [31:0]         inst,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [15:0]         imm,
    output logic [25:0]         jidx,
    output logic [INST_NUM-1:0] inst_hit
);

    logic [63:0] op_d;
    logic [63:0] func_d;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [31:0] rd_d;
    logic [31:0] sa_d;
    logic        r_alu;
    logic        r_shift;
    logic        decode_unused;

    assign rs   = inst[25:21];
    assign rt   = inst[20:16];
    assign rd   = inst[15:11];
    assign imm  = inst[15:0];
    assign jidx = inst[25:0];

    assign op_d   = decoder_6_64(inst[31:26]);
    assign func_d = decoder_6_64(inst[5:0]);
    assign rs_d   = decoder_5_32(inst[25:21]);
    assign rt_d   = decoder_5_32(inst[20:16]);
    assign rd_d   = decoder_5_32(inst[15:11]);
    assign sa_d   = decoder_5_32(inst[10:6]);

    // Register-register ALU ops need sa == 0; immediate shifts need rs == 0.
    assign r_alu   = op_d[6'h00] & sa_d[0];
    assign r_shift = op_d[6'h00] & rs_d[0];

    assign inst_hit[I_ADDU]  = r_alu   & func_d[6'h21];
    assign inst_hit[I_SUBU]  = r_alu   & func_d[6'h23];
    assign inst_hit[I_SLT]   = r_alu   & func_d[6'h2a];
    assign inst_hit[I_SLTU]  = r_alu   & func_d[6'h2b];
    assign inst_hit[I_AND]   = r_alu   & func_d[6'h24];
    assign inst_hit[I_OR]    = r_alu   & func_d[6'h25];
    assign inst_hit[I_XOR]   = r_alu   & func_d[6'h26];
    assign inst_hit[I_NOR]   = r_alu   & func_d[6'h27];
    assign inst_hit[I_SLL]   = r_shift & func_d[6'h00];
    assign inst_hit[I_SRL]   = r_shift & func_d[6'h02];
    assign inst_hit[I_SRA]   = r_shift & func_d[6'h03];
    assign inst_hit[I_ADDIU] = op_d[6'h09];
    assign inst_hit[I_LUI]   = op_d[6'h0f] & rs_d[0];
    assign inst_hit[I_LW]    = op_d[6'h23];
    assign inst_hit[I_SW]    = op_d[6'h2b];
    assign inst_hit[I_BEQ]   = op_d[6'h04];
    assign inst_hit[I_BNE]   = op_d[6'h05];
    assign inst_hit[I_JAL]   = op_d[6'h03];
    assign inst_hit[I_JR]    = op_d[6'h00] & func_d[6'h08] & rt_d[0] & rd_d[0] & sa_d[0];

    // Only a few decoder outputs are consumed; fold the rest into a sink.
    assign decode_unused = ^{op_d, func_d, rs_d, rt_d, rd_d, sa_d};

endmodule

// File: rtl/id_stage.sv
// id_stage: instruction decode stage of a 5-stage MIPS-subset pipeline.
// Holds one instruction, decodes it, reads the register file, detects RAW
// hazards against EX/MEM/WB (stall only, no forwarding) and resolves branches.
// Ports:
//   clk, resetn                   - clock, async active-low reset
//   fs_to_ds_valid/fs_to_ds_bus   - instruction from fetch {inst, pc}
//   ds_allowin                    - decode can accept this cycle
//   es_allowin                    - execute can accept this cycle
//   ds_to_es_valid/ds_to_es_bus   - decoded instruction toward execute
//   rf_raddr1/2, rf_rdata1/2      - combinational register-file read
//   es_dest/ms_dest/ws_dest       - {valid&gr_we, dest} of downstream stages
//   br_bus                        - {br_taken, br_target}
//
// Handshake: a stage transfers on a rising edge where the producer's valid and
// the consumer's allowin are both high in the preceding cycle. A producer
// holding valid without allowin keeps its bus stable until the transfer.
module id_stage
    import cpu_defs::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       fs_to_ds_valid,
    input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       ds_allowin,
    input  logic                       es_allowin,
    output logic                       ds_to_es_valid,
    output logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic [4:0]                 rf_raddr1,
    output logic [4:0]                 rf_raddr2,
    input  logic [31:0]                rf_rdata1,
    input  logic [31:0]                rf_rdata2,
    input  logic [DEST_BUS_WD-1:0]     es_dest,
    input  logic [DEST_BUS_WD-1:0]     ms_dest,
    input  logic [DEST_BUS_WD-1:0]     ws_dest,
    output logic [BR_BUS_WD-1:0]       br_bus
);

    logic                       ds_valid;
    logic                       ds_ready_go;
    logic [FS_TO_DS_BUS_WD-1:0] ds_bus_r;
    logic [31:0]                ds_inst;
    logic [31:0]                ds_pc;

    logic [4:0]                 rs;
    logic [4:0]                 rt;
    logic [4:0]                 rd;
    logic [15:0]                imm;
    logic [25:0]                jidx;
    logic [INST_NUM-1:0]        hit;

    logic [ALU_OP_WD-1:0]       alu_op;
    logic                       load_op;
    logic                       store_op;
    logic                       src1_is_sa;
    logic                       src1_is_pc;
    logic                       src2_is_imm;
    logic                       src2_is_8;
    logic                       gr_we;
    logic [4:0]                 dest;
    logic                       dst_is_rd;
    logic                       dst_is_rt;
    logic                       reads_rs;
    logic                       reads_rt;
    logic                       rs_hazard;
    logic                       rt_hazard;

    logic [31:0]                rs_value;
    logic [31:0]                rt_value;
    logic                       rs_eq_rt;
    logic                       br_taken;
    logic [31:0]                br_target;
    logic [31:0]                pc_plus4;
    logic [31:0]                br_offset;

    assign ds_inst = ds_bus_r[63:32];
    assign ds_pc   = ds_bus_r[31:0];

    // ---------------- pipeline register ----------------
    assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
    assign ds_to_es_valid = ds_valid && ds_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_valid <= 1'b0;
        end else if (ds_allowin) begin
            ds_valid <= fs_to_ds_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_bus_r <= '0;
        end else if (fs_to_ds_valid && ds_allowin) begin
            ds_bus_r <= fs_to_ds_bus;
        end
    end

    // ---------------- decode ----------------
    inst_decode u_inst_decode (
        .inst     (ds_inst),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .imm      (imm),
        .jidx     (jidx),
        .inst_hit (hit)
    );

    assign alu_op[ALU_ADD]  = hit[I_ADDU] | hit[I_ADDIU] | hit[I_LW] | hit[I_SW] | hit[I_JAL];
    assign alu_op[ALU_SUB]  = hit[I_SUBU];
    assign alu_op[ALU_SLT]  = hit[I_SLT];
    assign alu_op[ALU_SLTU] = hit[I_SLTU];
    assign alu_op[ALU_AND]  = hit[I_AND];
    assign alu_op[ALU_NOR]  = hit[I_NOR];
    assign alu_op[ALU_OR]   = hit[I_OR];
    assign alu_op[ALU_XOR]  = hit[I_XOR];
    assign alu_op[ALU_SLL]  = hit[I_SLL];
    assign alu_op[ALU_SRL]  = hit[I_SRL];
    assign alu_op[ALU_SRA]  = hit[I_SRA];
    assign alu_op[ALU_LUI]  = hit[I_LUI];

    assign load_op     = hit[I_LW];
    assign store_op    = hit[I_SW];
    assign src1_is_sa  = hit[I_SLL] | hit[I_SRL] | hit[I_SRA];
    assign src1_is_pc  = hit[I_JAL];
    assign src2_is_imm = hit[I_ADDIU] | hit[I_LUI] | hit[I_LW] | hit[I_SW];
    assign src2_is_8   = hit[I_JAL];

    assign dst_is_rd = |hit[I_SRA:I_ADDU];
    assign dst_is_rt = hit[I_ADDIU] | hit[I_LUI] | hit[I_LW];
    assign gr_we     = dst_is_rd | dst_is_rt | hit[I_JAL];

    always_comb begin
        dest = 5'd0;
        if (dst_is_rd) begin
            dest = rd;
        end else if (dst_is_rt) begin
            dest = rt;
        end else if (hit[I_JAL]) begin
            dest = 5'd31;
        end
    end

    // ---------------- register read and hazard ----------------
    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;
    assign rs_value  = rf_rdata1;
    assign rt_value  = rf_rdata2;

    // Shifts take sa instead of rs; addiu/lui/lw write rt rather than read it.
    assign reads_rs = (|hit[I_NOR:I_ADDU]) | hit[I_ADDIU] | hit[I_LW] | hit[I_SW]
                    | hit[I_BEQ] | hit[I_BNE] | hit[I_JR];
    assign reads_rt = (|hit[I_SRA:I_ADDU]) | hit[I_SW] | hit[I_BEQ] | hit[I_BNE];

    function automatic logic dest_match(input logic [DEST_BUS_WD-1:0] d, input logic [4:0] r);
        return d[5] && (d[4:0] == r);
    endfunction

    assign rs_hazard = reads_rs && (rs != 5'd0) &&
                       (dest_match(es_dest, rs) || dest_match(ms_dest, rs) || dest_match(ws_dest, rs));
    assign rt_hazard = reads_rt && (rt != 5'd0) &&
                       (dest_match(es_dest, rt) || dest_match(ms_dest, rt) || dest_match(ws_dest, rt));

    assign ds_ready_go = !(rs_hazard || rt_hazard);

    // ---------------- branch resolution ----------------
    assign rs_eq_rt  = (rs_value == rt_value);
    assign pc_plus4  = ds_pc + 32'd4;
    assign br_offset = {{14{imm[15]}}, imm, 2'b00};

    // A stalled branch reads stale operands, so it must not redirect yet.
    assign br_taken = ds_valid && ds_ready_go &&
                      ((hit[I_BEQ] && rs_eq_rt) || (hit[I_BNE] && !rs_eq_rt) ||
                       hit[I_JAL] || hit[I_JR]);

    always_comb begin
        br_target = pc_plus4 + br_offset;
        if (hit[I_JAL]) begin
            br_target = {pc_plus4[31:28], jidx, 2'b00};
        end else if (hit[I_JR]) begin
            br_target = rs_value;
        end
    end

    assign br_bus = {br_taken, br_target};

    assign ds_to_es_bus = {alu_op, load_op, store_op, src1_is_sa, src1_is_pc,
                           src2_is_imm, src2_is_8, gr_we, dest, imm,
                           rs_value, rt_value, ds_pc};

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1, reset: asynchronous, active-low.
REQ-003 SHALL have port fs_to_ds_valid, input, 1, fetch stage holds a valid instruction.
REQ-004 SHALL have port fs_to_ds_bus, input, 64, {inst[31:0], pc[31:0]}.
REQ-005 SHALL have port ds_allowin, output, 1, ID can accept a new instruction this cycle.
REQ-006 SHALL have port es_allowin, input, 1, EX stage can accept.
REQ-007 SHALL have port ds_to_es_valid, output, 1, decoded instruction valid toward EX.
REQ-008 SHALL have port ds_to_es_bus, output, 136, {alu_op[11:0], load_op, store_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8, gr_we, dest[4:0], imm[15:0], rs_value[31:0], rt_value[31:0], pc[31:0]} (MSB first).
REQ-009 SHALL have ports rf_raddr1, rf_raddr2, output, 5 each, and rf_rdata1, rf_rdata2, input, 32 each: combinational regfile read.
REQ-010 SHALL have ports es_dest, ms_dest, ws_dest, input, 6 each, {valid&gr_we, dest[4:0]} of downstream stages.
REQ-011 SHALL have port br_bus, output, 33, {br_taken, br_target[31:0]}.

Function
REQ-012 SHALL hold one instruction in register ds_valid plus a 64-bit bus latch.
REQ-013 SHALL drive ds_allowin = !ds_valid | (ds_ready_go & es_allowin); ds_to_es_valid = ds_valid & ds_ready_go.
REQ-014 SHALL load ds_valid <= fs_to_ds_valid when ds_allowin; SHALL capture fs_to_ds_bus only when fs_to_ds_valid & ds_allowin; otherwise hold.
REQ-015 SHALL decode: addu subu slt sltu and or xor nor sll srl sra addiu lui lw sw beq bne jal jr; alu_op one-hot order add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui (bit 0 = add).
REQ-016 SHALL use add for addiu/lw/sw/jal; imm sign-extension is EX's job, ID passes raw imm[15:0].
REQ-017 SHALL set dest = rd (R-type), rt (addiu/lui/lw), 31 (jal); dest = 0 whenever gr_we = 0.
REQ-018 SHALL set gr_we = 0 for sw, beq, bne, jr and any unrecognised encoding; unrecognised instructions SHALL behave as NOP (no branch, no write).
REQ-019 SHALL set src1_is_pc & src2_is_8 for jal (link = pc+8); src1_is_sa for shifts.
REQ-020 SHALL drive rf_raddr1 = rs, rf_raddr2 = rt combinationally from the latched instruction.
REQ-021 SHALL stall (ds_ready_go = 0) when ds_valid and an operand actually read (rs, and/or rt) is nonzero and equals the dest of any of es/ms/ws with bit 5 set; no forwarding.
REQ-022 SHALL compare rs_value/rt_value for beq/bne in ID; br_taken = ds_valid & ds_ready_go & (beq&eq | bne&!eq | jal | jr).
REQ-023 SHALL compute br_target = pc+4+(sext(imm)<<2) for branches, {pc+4[31:28], instr_index, 2'b00} for jal, rs_value for jr; 32-bit wrap-around, no overflow trap.
REQ-024 SHALL NOT flush the delay slot; a stalled branch SHALL keep br_taken = 0 until the hazard clears.
REQ-025 SHALL hold ds_to_es_bus stable while ds_to_es_valid & !es_allowin.

Reset
REQ-026 SHALL on resetn low asynchronously clear ds_valid and the bus latch to 0.
REQ-027 SHALL during reset present ds_allowin = 1, ds_to_es_valid = 0, br_taken = 0; reset mid-stall SHALL discard the held instruction.

Structure
REQ-028 SHALL place bus widths (64, 136, 33, 6) and alu_op bit indices in the shared package cpu_defs.
REQ-029 SHALL use one combinational sub-module inst_decode (field split plus decoder_6_64 for opcode/func, decoder_5_32 for rs/rt/rd/sa) producing instruction one-hots.

Verification
REQ-030 SHALL check: addu $3,$1,$2 at pc 0xBFC00000, es_allowin=1 -> next cycle ds_to_es_valid=1, alu_op=0x001, dest=3, gr_we=1.
REQ-031 SHALL check: es_dest=6'h21 with instruction reading $1 -> ds_ready_go=0, ds_allowin=0 until es_dest clears, then issue.
REQ-032 SHALL check: beq $4,$5 imm=0xFFFF, pc=0x100, rf_rdata equal -> br_bus={1,0x100}; unequal -> br_taken=0.
REQ-033 SHALL check: jal instr_index=0x0000040 at pc 0xBFC00010 -> target 0xB0000100, dest=31, src2_is_8=1.
REQ-034 SHALL check: es_allowin=0 for 3 cycles -> ds_to_es_bus unchanged, fs bus not captured; resetn low mid-hold -> ds_to_es_valid=0 immediately.
REQ-035 SHALL check: encoding 0xFC000000 -> gr_we=0, dest=0, br_taken=0, flows through as NOP.
